pipelined_processor_fwd: RTL and testbench

//  Parametrised 4-stage (IF/ID/EX/WB) in-order core; successor of the fixed 8-bit ADD/SUB/AND/LOAD pipeline.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/pipelined_processor_fwd_if.sv | 23 ++
 rtl/cpu_alu.sv | 19 +
 rtl/pipelined_processor_fwd.sv | 95 +++++++++
 tb/tb_pipelined_processor_fwd.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field slicers, op classifiers and the per-stage valid bits shared by the core
package cpu_pkg;
  typedef logic [15:0] instr_t;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_LOAD = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_OR = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef struct packed {
    logic fd;
    logic de;
    logic ew;
  } stage_valid_t;
  function automatic logic [3:0] f_op(instr_t i);
    return i[15:12];
  endfunction
  function automatic logic [3:0] f_rd(instr_t i);
    return i[11:8];
  endfunction
  function automatic logic [3:0] f_rs1(instr_t i);
    return i[7:4];
  endfunction
  function automatic logic [3:0] f_rs2(instr_t i);
    return i[3:0];
  endfunction
  function automatic logic [7:0] f_imm8(instr_t i);
    return i[7:0];
  endfunction
  function automatic logic writes_reg(logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LOAD, OP_LDI};
  endfunction
  function automatic logic retires(logic [3:0] op);
    return op != OP_NOP && op <= OP_BEQZ;
  endfunction
endpackage

// File: rtl/pipelined_processor_fwd_if.sv
// pipelined_processor_fwd_if: core control/status bus -- run, IMEM load port, debug register read, halted/pc_out/retire_count
interface pipelined_processor_fwd_if #(
  parameter int DATA_W = 8,
  parameter int IMEM_AW = 8
);
  logic run;
  logic imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic [3:0] dbg_raddr;
  logic [DATA_W-1:0] dbg_rdata;
  logic halted;
  logic [IMEM_AW-1:0] pc_out;
  logic [15:0] retire_count;
  modport master (
    output run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
    input dbg_rdata, halted, pc_out, retire_count
  );
  modport slave (
    input run, imem_we, imem_waddr, imem_wdata, dbg_raddr,
    output dbg_rdata, halted, pc_out, retire_count
  );
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU (op, a, b -> result, zero); LOAD/STORE add for the address, LDI passes b, everything else passes a
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  assign result = op == OP_ADD || op == OP_LOAD || op == OP_STORE ? a + b
                : op == OP_SUB ? a - b
                : op == OP_AND ? a & b
                : op == OP_OR ? a | b
                : op == OP_XOR ? a ^ b
                : op == OP_LDI ? b
                : a;
  assign zero = result == '0;
endmodule

// File: rtl/pipelined_processor_fwd.sv
// pipelined_processor_fwd: 4-stage IF/ID/EX/WB core with full forwarding and branch flush; ports clk, reset_n (async low), bus (slave: run, imem load, debug read, status)
module pipelined_processor_fwd import cpu_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8
) (
  input logic clk,
  input logic reset_n,
  pipelined_processor_fwd_if.slave bus
);
  logic [15:0] imem [2**IMEM_AW];
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] dmem [2**DMEM_AW];
  logic [IMEM_AW-1:0] pc, fd_pc, de_pc, target;
  instr_t fd_instr, de_instr;
  logic [DATA_W-1:0] de_a, de_b, de_d, ew_res;
  logic [DATA_W-1:0] id_a, id_b, id_d, a, b, d, alu_a, alu_b, alu_y, ex_res;
  logic [3:0] ew_op, ew_rd, op;
  logic [7:0] imm8;
  logic [DMEM_AW-1:0] addr;
  stage_valid_t v;
  logic halted, adv, ew_fwd, taken, halt_ex, squash, zero;
  logic [15:0] retire_count;
  // rf[0] is never written, so plain reads of R0 return 0 without a special case
  assign ew_fwd = v.ew && writes_reg(ew_op) && ew_rd != 4'd0;
  assign id_a = ew_fwd && ew_rd == f_rs1(fd_instr) ? ew_res : rf[f_rs1(fd_instr)];
  assign id_b = ew_fwd && ew_rd == f_rs2(fd_instr) ? ew_res : rf[f_rs2(fd_instr)];
  assign id_d = ew_fwd && ew_rd == f_rd(fd_instr) ? ew_res : rf[f_rd(fd_instr)];
  assign op = f_op(de_instr);
  assign imm8 = f_imm8(de_instr);
  assign a = ew_fwd && ew_rd == f_rs1(de_instr) ? ew_res : de_a;
  assign b = ew_fwd && ew_rd == f_rs2(de_instr) ? ew_res : de_b;
  assign d = ew_fwd && ew_rd == f_rd(de_instr) ? ew_res : de_d;
  // BEQZ tests R[rd] through the ALU pass-through so zero doubles as the branch condition
  assign alu_a = op == OP_BEQZ ? d : a;
  assign alu_b = op == OP_LOAD || op == OP_STORE ? DATA_W'(f_rs2(de_instr))
               : op == OP_LDI ? DATA_W'(imm8)
               : b;
  cpu_alu #(.DATA_W(DATA_W)) alu (
    .op(op),
    .a(alu_a),
    .b(alu_b),
    .result(alu_y),
    .zero(zero)
  );
  assign addr = DMEM_AW'(alu_y);
  assign ex_res = op == OP_LOAD ? dmem[addr] : alu_y;
  assign target = de_pc + IMEM_AW'({{IMEM_AW{imm8[7]}}, imm8});
  assign adv = bus.run && !halted;
  assign taken = v.de && op == OP_BEQZ && zero;
  assign halt_ex = v.de && op == OP_HALT;
  assign squash = taken || halt_ex;
  assign bus.dbg_rdata = rf[bus.dbg_raddr];
  assign bus.halted = halted;
  assign bus.pc_out = pc;
  assign bus.retire_count = retire_count;
  always_ff @(posedge clk)
    if (bus.imem_we) imem[bus.imem_waddr] <= bus.imem_wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc <= '0;
      fd_pc <= '0;
      de_pc <= '0;
      fd_instr <= '0;
      de_instr <= '0;
      de_a <= '0;
      de_b <= '0;
      de_d <= '0;
      ew_res <= '0;
      ew_op <= '0;
      ew_rd <= '0;
      v <= '0;
      halted <= 1'b0;
      retire_count <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      for (int i = 0; i < 2**DMEM_AW; i++) dmem[i] <= '0;
    end else if (adv) begin
      pc <= taken ? target : pc + IMEM_AW'(1);
      v <= '{fd: !squash, de: v.fd && !squash, ew: v.de};
      fd_instr <= imem[pc];
      fd_pc <= pc;
      de_instr <= fd_instr;
      de_pc <= fd_pc;
      de_a <= id_a;
      de_b <= id_b;
      de_d <= id_d;
      ew_op <= op;
      ew_rd <= f_rd(de_instr);
      ew_res <= ex_res;
      halted <= halt_ex;
      if (ew_fwd) rf[ew_rd] <= ew_res;
      if (v.de && op == OP_STORE) dmem[addr] <= d;
      if (v.ew && retires(ew_op) && retire_count != 16'hFFFF) retire_count <= retire_count + 16'd1;
    end
endmodule

// File: tb/tb_pipelined_processor_fwd.sv
// tb_pipelined_processor_fwd: directed and random programs checked against an instruction-level model of the ISA
module tb_pipelined_processor_fwd;
  localparam int DW = 16;
  localparam int IAW = 8;
  localparam int DAW = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [15:0] prog [$];
  logic [DW-1:0] m_r [16];
  logic [DW-1:0] m_m [256];
  int m_ret;
  int m_hpc;
  logic [31:0] v;
  always #5 clk = ~clk;
  pipelined_processor_fwd_if #(.DATA_W(DW), .IMEM_AW(IAW)) bus ();
  pipelined_processor_fwd #(.DATA_W(DW), .IMEM_AW(IAW), .DMEM_AW(DAW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void put(input logic [3:0] r, input logic [DW-1:0] x);
    if (r != 4'd0) m_r[r] = x;
  endfunction
  task automatic model();
    int pc;
    int off;
    logic [15:0] i;
    logic [3:0] op, rd, rs1, rs2;
    logic [DW-1:0] a, b, d, ea;
    for (int k = 0; k < 16; k++) m_r[k] = '0;
    for (int k = 0; k < 256; k++) m_m[k] = '0;
    m_ret = 0;
    m_hpc = -1;
    pc = 0;
    for (int s = 0; s < 1000 && m_hpc < 0; s++) begin
      i = pc < prog.size() ? prog[pc] : 16'hF000;
      {op, rd, rs1, rs2} = i;
      a = m_r[rs1];
      b = m_r[rs2];
      d = m_r[rd];
      ea = a + DW'(rs2);
      off = 1;
      if (op == 4'hF) m_hpc = pc;
      else begin
        if (op >= 4'h1 && op <= 4'h9) m_ret++;
        case (op)
          4'h1: put(rd, a + b);
          4'h2: put(rd, a - b);
          4'h3: put(rd, a & b);
          4'h6: put(rd, a | b);
          4'h7: put(rd, a ^ b);
          4'h4: put(rd, m_m[ea[7:0]]);
          4'h5: m_m[ea[7:0]] = d;
          4'h8: put(rd, DW'(i[7:0]));
          4'h9: if (d == '0) off = $signed(i[7:0]);
          default: ;
        endcase
        pc = (pc + off) & 255;
      end
    end
  endtask
  task automatic gen(input int len);
    logic [3:0] ops [14];
    logic [3:0] o, rd, r1, r2;
    ops = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h4, 4'h5, 4'h8, 4'h8, 4'h8, 4'h9, 4'h0, 4'hA, 4'hD};
    prog.delete();
    for (int k = 0; k < len; k++) begin
      o = ops[$urandom_range(0, 13)];
      rd = 4'($urandom_range(0, 5));
      r1 = 4'($urandom_range(0, 5));
      r2 = (o == 4'h4 || o == 4'h5) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      prog.push_back(o == 4'h9 ? {o, rd, 8'($urandom_range(1, 4))} : o == 4'h8 ? {o, rd, 8'($urandom)} : {o, rd, r1, r2});
    end
    prog.push_back(16'hF000);
  endtask
  task automatic rd_reg(input int k, output logic [31:0] x);
    @(negedge clk);
    bus.dbg_raddr = 4'(k);
    #1;
    x = 32'(bus.dbg_rdata);
  endtask
  task automatic load_and_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    bus.run = 1'b0;
    #1;
    check({tag, " rst pc"}, 32'(bus.pc_out), 0);
    check({tag, " rst halted"}, 32'(bus.halted), 0);
    check({tag, " rst retire"}, 32'(bus.retire_count), 0);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      bus.imem_we = 1'b1;
      bus.imem_waddr = 8'(k);
      bus.imem_wdata = k < prog.size() ? prog[k] : 16'hF000;
    end
    @(negedge clk);
    bus.imem_we = 1'b0;
    reset_n = 1'b1;
  endtask
  task automatic run_to_halt(input string tag, input bit rnd);
    int cyc;
    cyc = 0;
    while (!bus.halted && cyc < 3000) begin
      @(negedge clk);
      bus.run = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc++;
    end
    check({tag, " halted"}, 32'(bus.halted), 1);
    bus.run = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic check_arch(input string tag);
    logic [31:0] x;
    for (int k = 0; k < 16; k++) begin
      rd_reg(k, x);
      check($sformatf("%s R%0d", tag, k), x, 32'(m_r[k]));
    end
    check({tag, " retire"}, 32'(bus.retire_count), 32'(m_ret));
    check({tag, " pc frozen"}, 32'(bus.pc_out), 32'((m_hpc + 3) & 255));
  endtask
  task automatic full_run(input string tag, input bit rnd);
    load_and_reset(tag);
    model();
    run_to_halt(tag, rnd);
    check_arch(tag);
  endtask
  initial begin
    bus.run = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.dbg_raddr = '0;
    prog = {16'h8207, 16'h8304, 16'h1123, 16'h2412, 16'hF000};
    full_run("t1", 1'b0);
    rd_reg(1, v);
    check("t1 r1", v, 11);
    rd_reg(4, v);
    check("t1 r4", v, 4);
    prog = {16'h810A, 16'h82AA, 16'h520A, 16'h4610, 16'h7766, 16'hF000};
    full_run("t2", 1'b0);
    rd_reg(6, v);
    check("t2 r6", v, 32'hAA);
    rd_reg(7, v);
    check("t2 r7", v, 0);
    check("t2 retire", 32'(bus.retire_count), 5);
    prog = {16'h8100, 16'h9103, 16'h8501, 16'h8502, 16'h8503, 16'hF000};
    full_run("t3", 1'b0);
    rd_reg(5, v);
    check("t3 r5", v, 3);
    check("t3 retire", 32'(bus.retire_count), 3);
    prog = {16'h8205, 16'h8306, 16'h1023, 16'h1100, 16'hF000};
    full_run("t4", 1'b0);
    rd_reg(1, v);
    check("t4 r1", v, 0);
    prog = {16'hF000, 16'h8909};
    full_run("t5", 1'b0);
    rd_reg(9, v);
    check("t5 r9", v, 0);
    check("t5 pc", 32'(bus.pc_out), 3);
    prog = {16'h8105, 16'h8203, 16'h1312, 16'h2431, 16'h7541, 16'hF000};
    load_and_reset("t5run");
    model();
    repeat (6) begin
      @(negedge clk);
      bus.run = 1'b1;
    end
    @(negedge clk);
    bus.run = 1'b0;
    repeat (4) @(negedge clk);
    check("t5run pc", 32'(bus.pc_out), 6);
    check("t5run retire", 32'(bus.retire_count), 3);
    check("t5run halted", 32'(bus.halted), 0);
    rd_reg(3, v);
    check("t5run r3", v, 8);
    rd_reg(4, v);
    check("t5run r4", v, 0);
    run_to_halt("t5run", 1'b0);
    check_arch("t5run");
    prog = {16'h810A, 16'h82AA, 16'h520A, 16'h4610, 16'h7766, 16'hF000};
    load_and_reset("t6");
    repeat (7) begin
      @(negedge clk);
      bus.run = 1'b1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("t6 pc", 32'(bus.pc_out), 0);
    check("t6 halted", 32'(bus.halted), 0);
    check("t6 retire", 32'(bus.retire_count), 0);
    for (int k = 1; k < 16; k++) begin
      rd_reg(k, v);
      check($sformatf("t6 R%0d", k), v, 0);
    end
    bus.run = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model();
    run_to_halt("t6b", 1'b0);
    check_arch("t6b");
    for (int t = 0; t < 12; t++) begin
      gen($urandom_range(8, 24));
      full_run($sformatf("rnd%0d", t), 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
